// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared size codes, FSM states and constants for the MEM stage
package mem_access_pkg;

   localparam int BE_W               = 4;
   localparam int TIMEOUT_CYCLES_DEF = 16;

   // funct3[1:0] carries the access size, funct3[2] selects zero extension
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      return ((f3[1:0] == SZ_H) && addr_lo[0]) || ((f3[1:0] == SZ_W) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// rtl/mem_access_load_align.sv - load lane extract with sign/zero extension
module mem_access_load_align
   import mem_access_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_funct3[1:0])
         SZ_B:    o_data = i_funct3[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
         SZ_H:    o_data = i_funct3[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: req/ready data-memory FSM, lane alignment, MEM/WB register
// Define MEM_TIMEOUT_EN to abort a WAIT that sees no dmem_ready within TIMEOUT_CYCLES.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   input  logic [ADDR_WIDTH-1:0] ALU_result,
   input  logic [DATA_WIDTH-1:0] store_data,
   input  logic [2:0]            funct3,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic                  RegWrite,
   input  logic                  MemtoReg,
   input  logic [4:0]            rd,
   output logic                  mem_stall,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic [BE_W-1:0]       dmem_be,
   input  logic                  dmem_ready,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  wb_valid,
   output logic                  wb_RegWrite,
   output logic                  wb_MemtoReg,
   output logic [4:0]            wb_rd,
   output logic [DATA_WIDTH-1:0] wb_ALU_result,
   output logic [DATA_WIDTH-1:0] wb_mem_data,
   output logic                  wb_misaligned,
   output logic                  wb_bus_err
);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [2:0]              r_f3;
   logic                    r_memread;
   logic                    r_regwrite;
   logic                    r_memtoreg;
   logic [4:0]              r_rd;
   logic                    w_memop;
   logic                    w_mis;
   logic                    w_issue;
   logic                    w_done;
   logic                    w_tmo;
   logic [BE_W-1:0]         w_be;
   logic [DATA_WIDTH-1:0]   w_wdata;
   logic [31:0]             w_load;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  r_cnt <= '0;
      else if (r_state == ST_IDLE) r_cnt <= '0;
      else if (!dmem_ready)        r_cnt <= r_cnt + CNT_W'(1);
   end
`else
   logic w_unused_timeout_cfg;
   assign w_unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

   always_comb begin
      w_memop = MemRead | MemWrite;
      w_mis   = is_misaligned(funct3, ALU_result[1:0]);
      w_issue = valid_in & w_memop & ~w_mis;
      case (funct3[1:0])
         SZ_B: begin
            w_be    = 4'b0001 << ALU_result[1:0];
            w_wdata = {4{store_data[7:0]}};
         end
         SZ_H: begin
            w_be    = ALU_result[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{store_data[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = store_data;
         end
      endcase
   end

   // The abort cycle releases the stall so upstream retires the faulted instruction.
   always_comb begin
      w_state_nxt = r_state;
      mem_stall   = 1'b0;
      w_done      = 1'b0;
      w_tmo       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_issue) begin
               mem_stall   = 1'b1;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dmem_ready) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_tmo       = 1'b1;
               w_state_nxt = ST_IDLE;
            end
`endif
            mem_stall = ~dmem_ready & ~w_tmo;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   mem_access_load_align u_load_align (
      .i_rdata   (dmem_rdata),
      .i_addr_lo (r_addr[1:0]),
      .i_funct3  (r_f3),
      .o_data    (w_load)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         dmem_be       <= '0;
         r_addr        <= '0;
         r_f3          <= '0;
         r_memread     <= 1'b0;
         r_regwrite    <= 1'b0;
         r_memtoreg    <= 1'b0;
         r_rd          <= '0;
         wb_valid      <= 1'b0;
         wb_RegWrite   <= 1'b0;
         wb_MemtoReg   <= 1'b0;
         wb_rd         <= '0;
         wb_ALU_result <= '0;
         wb_mem_data   <= '0;
         wb_misaligned <= 1'b0;
         wb_bus_err    <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         if (w_issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite;
            dmem_addr  <= {ALU_result[ADDR_WIDTH-1:2], 2'b00};
            dmem_wdata <= w_wdata;
            dmem_be    <= w_be;
            r_addr     <= ALU_result;
            r_f3       <= funct3;
            r_memread  <= MemRead;
            r_regwrite <= RegWrite;
            r_memtoreg <= MemtoReg;
            r_rd       <= rd;
            wb_valid   <= 1'b0;
         end else begin
            wb_valid      <= valid_in;
            wb_RegWrite   <= valid_in & RegWrite & ~(w_memop & w_mis);
            wb_MemtoReg   <= MemtoReg;
            wb_rd         <= rd;
            wb_ALU_result <= DATA_WIDTH'(ALU_result);
            wb_mem_data   <= '0;
            wb_misaligned <= valid_in & w_memop & w_mis;
            wb_bus_err    <= 1'b0;
         end
      end else if (w_done || w_tmo) begin
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         wb_valid      <= 1'b1;
         wb_RegWrite   <= r_regwrite & ~w_tmo;
         wb_MemtoReg   <= r_memtoreg;
         wb_rd         <= r_rd;
         wb_ALU_result <= DATA_WIDTH'(r_addr);
         wb_mem_data   <= (w_done && r_memread) ? DATA_WIDTH'(w_load) : '0;
         wb_misaligned <= 1'b0;
         wb_bus_err    <= w_tmo;
      end
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the 5-stage pipeline: consumes the EX/MEM register (ALU_result as address, read_reg_2_with_forwarding as store data, control bits) and produces the MEM/WB register.
- Drives a req/ready data-memory port and performs byte/half/word alignment, byte enables and load sign/zero extension.
- Asserts mem_stall to the hazard unit while an access is outstanding.

Parameters:
- DATA_WIDTH, 32, register/memory data width.
- ADDR_WIDTH, 32, data address width.
- TIMEOUT_CYCLES, 16, WAIT-state cycle limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  EX/MEM holds a live instruction.
- ALU_result  in  ADDR_WIDTH  effective address, or ALU value for non-memory ops.
- store_data  in  DATA_WIDTH  forwarded rs2 value.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- MemRead  in  1  load.
- MemWrite  in  1  store.
- RegWrite  in  1  write-back enable.
- MemtoReg  in  1  selects load data for write-back.
- rd  in  5  destination register.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write request.
- dmem_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  access complete; rdata valid on the same cycle.
- dmem_rdata  in  DATA_WIDTH  read word.
- wb_valid  out  1  MEM/WB live.
- wb_RegWrite  out  1  MEM/WB RegWrite.
- wb_MemtoReg  out  1  MEM/WB MemtoReg.
- wb_rd  out  5  MEM/WB rd.
- wb_ALU_result  out  DATA_WIDTH  MEM/WB ALU value.
- wb_mem_data  out  DATA_WIDTH  extended load data.
- wb_misaligned  out  1  misaligned access flag.
- wb_bus_err  out  1  timeout flag (0 without MEM_TIMEOUT_EN).

Behaviour:
- Reset (asynchronous, any state): state=IDLE, dmem_req=0, dmem_we=0, dmem_be=0. All wb_* outputs, dmem_addr and dmem_wdata are 0.
- FSM has two states: IDLE and WAIT.
- IDLE, valid_in & !(MemRead|MemWrite):
  - At the next edge, wb_* take the inputs.
  - wb_valid=1, wb_mem_data=0.
  - No stall.
- IDLE, valid_in & memory op & aligned:
  - mem_stall=1 combinationally.
  - Next edge: latch address, data, be, size and control; state->WAIT; dmem_req=1 (registered); dmem_we=MemWrite; wb_valid=0 (bubble).
- Misaligned means: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - No request and no stall.
  - Next edge: wb_valid=1, wb_misaligned=1, wb_RegWrite=0.
- WAIT:
  - dmem_req and the address, data and be are held stable until dmem_ready.
  - mem_stall = !dmem_ready.
  - On dmem_ready: dmem_rdata is sampled. At that edge the load is extracted and extended into wb_mem_data, wb_valid=1, dmem_req=0, state->IDLE.
  - A store completes the same way with its latched RegWrite (0).
- Minimum memory-op latency: 2 cycles IDLE->WB with 1 stall cycle. Each cycle without ready adds one stall cycle.
- Store lanes:
  - B: be=1<<addr[1:0], wdata={4{data[7:0]}}.
  - H: be=addr[1]?1100:0011, wdata={2{data[15:0]}}.
  - W: be=1111.
- Load extract: byte/half selected by the latched addr[1:0]. B/H are sign-extended, BU/HU zero-extended.
- dmem_ready in IDLE is ignored. valid_in=0 in IDLE gives wb_valid=0 next cycle.
- Inputs are guaranteed held by upstream while mem_stall=1; the block never re-samples them in WAIT.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter clears on entering WAIT and increments each WAIT cycle without ready.
  - When the count reaches TIMEOUT_CYCLES-1 without ready: drop dmem_req, go to IDLE, and write wb_valid=1, wb_bus_err=1, wb_RegWrite=0.
- MEM_TIMEOUT_EN undefined: no counter, WAIT waits indefinitely, wb_bus_err tied 0.

Decomposition:
- Shared package: funct3 size codes, state encoding, dmem_be width constant, TIMEOUT_CYCLES default.
- One natural sub-module, load_align: combinational extract plus sign/zero extend from (rdata, addr[1:0], funct3).

Test Plan:
- ADD with ALU_result=0x1234 -> next cycle wb_valid=1, wb_ALU_result=0x1234, mem_stall never 1.
- SW addr 0x100, data 0xDEADBEEF, ready on the first WAIT cycle -> dmem_be=1111, dmem_we=1, mem_stall high 1 cycle, wb_valid one cycle later.
- LB addr 0x103, rdata 0x80FF_0000, ready after 3 WAIT cycles -> 3 stall cycles plus 1, wb_mem_data=0xFFFF_FF80. The same access with LBU gives 0x0000_0080.
- SH data 0x0000_ABCD addr 0x102 -> be=1100, wdata=0xABCD_ABCD. LW addr 0x102 -> no dmem_req, wb_misaligned=1, wb_RegWrite=0.
- rst_n low while in WAIT -> dmem_req=0 immediately, wb_valid=0; the post-reset ADD completes normally.
- MEM_TIMEOUT_EN with ready never asserted -> after 16 WAIT cycles wb_bus_err=1, mem_stall=0, state IDLE.
